// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and helpers for the memory port arbiter.
//   tam_t        access size encoding (64/32/16/8-bit)
//   arb_state_t  arbiter FSM states
//   BE_*         base byte-enable patterns per access size (lane 0 aligned)
//   base_be()    size -> base byte enables
//   be_to_mask() byte enables -> 64-bit bit mask
package mem_arb_pkg;

  typedef enum logic [1:0] {
    TAM_D = 2'b00,
    TAM_W = 2'b01,
    TAM_H = 2'b10,
    TAM_B = 2'b11
  } tam_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_t;

  localparam logic [7:0] BE_D = 8'hFF;
  localparam logic [7:0] BE_W = 8'h0F;
  localparam logic [7:0] BE_H = 8'h03;
  localparam logic [7:0] BE_B = 8'h01;

  function automatic logic [7:0] base_be(input tam_t tam);
    logic [7:0] be;
    case (tam)
      TAM_D:   be = BE_D;
      TAM_W:   be = BE_W;
      TAM_H:   be = BE_H;
      default: be = BE_B;
    endcase
    return be;
  endfunction

  function automatic logic [63:0] be_to_mask(input logic [7:0] be);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{be[i]}};
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for the 64-bit memory port.
//   tam        access size
//   off        address bits [2:0]
//   wdata      right-aligned store data
//   rdata      raw 64-bit memory read data
//   be         byte enables shifted into the addressed lane
//   misaligned address bits below the access size are nonzero
//   wdata_sh   store data shifted into its lane, masked to the enabled bytes
//   rdata_ex   read lane shifted down to bit 0, zero-extended
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  tam_t        tam,
  input  logic [2:0]  off,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  be,
  output logic        misaligned,
  output logic [63:0] wdata_sh,
  output logic [63:0] rdata_ex
);

  logic [7:0] base;
  logic [5:0] sh;

  always_comb begin
    base = base_be(tam);
    sh   = {off, 3'b000};
    be   = base << off;
    case (tam)
      TAM_D:   misaligned = (off != 3'd0);
      TAM_W:   misaligned = (off[1:0] != 2'd0);
      TAM_H:   misaligned = off[0];
      default: misaligned = 1'b0;
    endcase
    // Masking drops any stale upper bits the requester left above the size.
    wdata_sh = (wdata << sh) & be_to_mask(be);
    rdata_ex = (rdata >> sh) & be_to_mask(base);
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences the shared 64-bit memory port between instruction
// fetch and data load/store. All outputs are registered.
//   clk, reset_n                      clock, async active-low reset
//   if_req/if_addr -> if_rdata/ack/err fetch port (32-bit instruction)
//   d_req/we/tam/addr/wdata -> d_rdata/ack/err  data port
//   mem_addr/wdata/be/we, mem_rdata    memory macro port
//   busy                               FSM not in IDLE
// Build option: MEM_ARB_RR_EN selects round-robin arbitration instead of
// fixed data-over-fetch priority.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | samples requests, arbitrates
// ST_ACCESS  | address registered on memory pins
// ST_RD_WAIT | read latency counter running
// ST_RESP    | ack cycle
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_tam,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  output logic [63:0]       d_rdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_be,
  output logic              mem_we,
  input  logic [63:0]       mem_rdata,
  output logic              busy
);

  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

  arb_state_t state, next_state;

  logic        cur_data, cur_we;
  tam_t        cur_tam;
  logic [2:0]  cur_off;
  logic [2:0]  cnt, cnt_d;

  logic              any_req, grant_data;
  tam_t              g_tam;
  logic [ADDR_W-1:0] g_addr;

  tam_t        al_tam;
  logic [2:0]  al_off;
  logic [7:0]  al_be;
  logic        al_mis;
  logic [63:0] al_wdata, al_rdata;

  logic [ADDR_W-1:0] mem_addr_d;
  logic [63:0]       mem_wdata_d, d_rdata_d;
  logic [7:0]        mem_be_d;
  logic [31:0]       if_rdata_d;
  logic              mem_we_d, if_ack_d, if_err_d, d_ack_d, d_err_d, busy_d;

  assign any_req = d_req | if_req;

`ifdef MEM_ARB_RR_EN
  // 1 = data won the last grant, 0 = fetch; reset to fetch so a first tie goes to data.
  logic last_grant;
  assign grant_data = d_req & (~if_req | ~last_grant);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         last_grant <= 1'b0;
    else if (state == ST_IDLE && any_req) last_grant <= grant_data;
  end
`else
  assign grant_data = d_req;
`endif

  assign g_tam  = grant_data ? tam_t'(d_tam) : TAM_W;
  assign g_addr = grant_data ? d_addr : if_addr;

  // In IDLE the aligner sees the winning request; afterwards the latched one.
  assign al_tam = (state == ST_IDLE) ? g_tam : cur_tam;
  assign al_off = (state == ST_IDLE) ? g_addr[2:0] : cur_off;

  mem_lane_align u_align (
    .tam        (al_tam),
    .off        (al_off),
    .wdata      (d_wdata),
    .rdata      (mem_rdata),
    .be         (al_be),
    .misaligned (al_mis),
    .wdata_sh   (al_wdata),
    .rdata_ex   (al_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (any_req) next_state = al_mis ? ST_RESP : ST_ACCESS;
      ST_ACCESS:  next_state = cur_we ? ST_RESP : ST_RD_WAIT;
      ST_RD_WAIT: if (cnt == 3'd0) next_state = ST_RESP;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_be_d    = '0;
    mem_we_d    = 1'b0;
    if_ack_d    = 1'b0;
    if_err_d    = 1'b0;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;
    if_rdata_d  = if_rdata;
    d_rdata_d   = d_rdata;
    cnt_d       = cnt;
    busy_d      = (next_state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          if (al_mis) begin
            d_ack_d  = grant_data;
            d_err_d  = grant_data;
            if_ack_d = ~grant_data;
            if_err_d = ~grant_data;
          end else begin
            mem_addr_d  = {g_addr[ADDR_W-1:3], 3'b000};
            mem_be_d    = al_be;
            mem_we_d    = grant_data & d_we;
            mem_wdata_d = (grant_data & d_we) ? al_wdata : '0;
            cnt_d       = LAT_M1;
          end
        end
      end
      ST_ACCESS: if (cur_we) d_ack_d = 1'b1;
      ST_RD_WAIT: begin
        if (cnt == 3'd0) begin
          if (cur_data) begin
            d_rdata_d = al_rdata;
            d_ack_d   = 1'b1;
          end else begin
            if_rdata_d = al_rdata[31:0];
            if_ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt - 3'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_data <= 1'b0;
      cur_we   <= 1'b0;
      cur_tam  <= TAM_D;
      cur_off  <= '0;
    end else if (state == ST_IDLE && any_req) begin
      cur_data <= grant_data;
      cur_we   <= grant_data & d_we;
      cur_tam  <= g_tam;
      cur_off  <= g_addr[2:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      mem_we    <= 1'b0;
      if_ack    <= 1'b0;
      if_err    <= 1'b0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
      cnt       <= '0;
    end else begin
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_be    <= mem_be_d;
      mem_we    <= mem_we_d;
      if_ack    <= if_ack_d;
      if_err    <= if_err_d;
      d_ack     <= d_ack_d;
      d_err     <= d_err_d;
      if_rdata  <= if_rdata_d;
      d_rdata   <= d_rdata_d;
      busy      <= busy_d;
      cnt       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter with RD_LAT = 2.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_ack, if_err;
  logic              d_req, d_we;
  logic [1:0]        d_tam;
  logic [ADDR_W-1:0] d_addr;
  logic [63:0]       d_wdata, d_rdata;
  logic              d_ack, d_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata, mem_rdata;
  logic [7:0]        mem_be;
  logic              mem_we, busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .if_err    (if_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_tam     (d_tam),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .d_err     (d_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps at least once, then until the chosen ack is seen or max cycles pass.
  task automatic wait_ack(input bit data, input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (((data ? d_ack : if_ack) !== 1'b1) && n < max);
  endtask

  int n;
  int acks;

  initial begin
    reset_n   = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_tam     = 2'b00;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    step();
    step();
    chk("rst_busy",   busy,     0);
    chk("rst_mem_we", mem_we,   0);
    chk("rst_mem_be", mem_be,   0);
    chk("rst_d_ack",  d_ack,    0);
    chk("rst_if_ack", if_ack,   0);
    chk("rst_addr",   mem_addr, 0);
    reset_n = 1'b1;
    step();

    // 8-bit store at 0x13
    d_req = 1'b1; d_we = 1'b1; d_tam = 2'b11; d_addr = 32'h13; d_wdata = 64'hAB;
    step();
    chk("st_we",    mem_we,    1);
    chk("st_addr",  mem_addr,  32'h10);
    chk("st_be",    mem_be,    8'h08);
    chk("st_wdata", mem_wdata, 64'h0000_0000_AB00_0000);
    chk("st_busy",  busy,      1);
    step();
    chk("st_ack",     d_ack,  1);
    chk("st_we_once", mem_we, 0);
    chk("st_err",     d_err,  0);
    d_req = 1'b0; d_we = 1'b0;
    step();
    chk("st_ack_pulse", d_ack, 0);
    chk("st_idle",      busy,  0);

    // 16-bit load at 0x26
    d_tam = 2'b10; d_addr = 32'h26; mem_rdata = 64'h1234_0000_0000_0000;
    d_req = 1'b1;
    step();
    chk("ld_addr", mem_addr, 32'h20);
    chk("ld_be",   mem_be,   8'hC0);
    chk("ld_we",   mem_we,   0);
    wait_ack(1'b1, 10, n);
    chk("ld_lat",   n,       3);
    chk("ld_rdata", d_rdata, 64'h1234);
    chk("ld_err",   d_err,   0);
    d_req = 1'b0;
    step();

    // misaligned 32-bit load at 0x102
    d_tam = 2'b01; d_addr = 32'h102; d_req = 1'b1;
    step();
    chk("mis_d_ack", d_ack,  1);
    chk("mis_d_err", d_err,  1);
    chk("mis_be",    mem_be, 0);
    chk("mis_we",    mem_we, 0);
    d_req = 1'b0;
    step();
    chk("mis_ack_clr", d_ack,  0);
    chk("mis_err_clr", d_err,  0);
    chk("mis_be2",     mem_be, 0);

    // misaligned fetch at 0x41
    if_addr = 32'h41; if_req = 1'b1;
    step();
    chk("mis_if_ack", if_ack, 1);
    chk("mis_if_err", if_err, 1);
    chk("mis_if_be",  mem_be, 0);
    if_req = 1'b0;
    step();

    // fetch upper and lower halves
    mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    if_addr = 32'h44; if_req = 1'b1;
    step();
    chk("if44_addr", mem_addr, 32'h40);
    chk("if44_be",   mem_be,   8'hF0);
    wait_ack(1'b0, 10, n);
    chk("if44_lat",   n,        3);
    chk("if44_rdata", if_rdata, 32'hDEAD_BEEF);
    chk("if44_err",   if_err,   0);
    if_req = 1'b0;
    step();
    if_addr = 32'h40; if_req = 1'b1;
    step();
    chk("if40_be", mem_be, 8'h0F);
    wait_ack(1'b0, 10, n);
    chk("if40_lat",   n,        3);
    chk("if40_rdata", if_rdata, 32'hCAFE_F00D);
    if_req = 1'b0;
    step();

    // simultaneous requests: data first, fetch not lost
    mem_rdata = 64'h0123_4567_89AB_CDEF;
    d_tam = 2'b00; d_addr = 32'h08; d_we = 1'b0; if_addr = 32'h44;
    d_req = 1'b1; if_req = 1'b1;
    wait_ack(1'b1, 20, n);
    chk("tie1_d_lat",   n,       4);
    chk("tie1_if_idle", if_ack,  0);
    chk("tie1_rdata",   d_rdata, 64'h0123_4567_89AB_CDEF);
    // data requester immediately issues another load: second tie in IDLE
    d_tam = 2'b01; d_addr = 32'h10;
`ifdef MEM_ARB_RR_EN
    wait_ack(1'b0, 20, n);
    chk("tie2_if_lat",   n,        5);
    chk("tie2_if_rdata", if_rdata, 32'h0123_4567);
    if_req = 1'b0;
    wait_ack(1'b1, 20, n);
    chk("tie2_d_lat",   n,       5);
    chk("tie2_d_rdata", d_rdata, 64'h89AB_CDEF);
    d_req = 1'b0;
`else
    wait_ack(1'b1, 20, n);
    chk("tie2_d_lat",   n,       5);
    chk("tie2_d_rdata", d_rdata, 64'h89AB_CDEF);
    d_req = 1'b0;
    wait_ack(1'b0, 20, n);
    chk("tie2_if_lat",   n,        5);
    chk("tie2_if_rdata", if_rdata, 32'h0123_4567);
    if_req = 1'b0;
`endif
    step();

    // reset during RD_WAIT
    d_tam = 2'b00; d_addr = 32'h18; d_req = 1'b1;
    step();
    step();
    chk("rw_busy_pre", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rw_busy",     busy,     0);
    chk("rw_addr",     mem_addr, 0);
    chk("rw_be",       mem_be,   0);
    chk("rw_d_rdata",  d_rdata,  0);
    chk("rw_if_rdata", if_rdata, 0);
    chk("rw_d_ack",    d_ack,    0);
    d_req = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (d_ack === 1'b1 || if_ack === 1'b1) acks++;
    end
    chk("rw_no_ack", acks, 0);
    d_we = 1'b1; d_tam = 2'b11; d_addr = 32'h13; d_wdata = 64'hCD; d_req = 1'b1;
    step();
    chk("rw_next_we", mem_we,    1);
    chk("rw_next_wd", mem_wdata, 64'h0000_0000_CD00_0000);
    wait_ack(1'b1, 10, n);
    chk("rw_next_lat", n, 1);
    d_req = 1'b0; d_we = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
